u_recv: RTL and testbench

U_RECV -- requirements
Module: u_recv

---
 rtl/u_recv.sv | 146 ++++++++++++++
 tb/tb_u_recv.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/u_recv.sv
// u_recv -- 16x oversampled 8N1 UART receiver with framing-error and break handling.
// Optional feature macro: U_RECV_MAJORITY_EN selects 2-of-3 majority sampling (+1 clock latency).
module u_recv #(
    parameter int SAMPLE_PT = 7
) (
    input  logic       sys_clk,
    input  logic       sys_rst_l,
    input  logic       uart_recH,
    output logic [7:0] rec_dataH,
    output logic       rec_readyH,
    output logic       rec_errH,
    output logic       rec_busyH
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

`ifdef U_RECV_MAJORITY_EN
    // The vote resolves one clock after the centre sample, so each new cell is entered one tick in.
    localparam logic [3:0] START_PT  = 4'(SAMPLE_PT + 1);
    localparam logic [3:0] CELL_PT   = 4'd0;
    localparam logic [3:0] CELL_LOAD = 4'd1;
`else
    localparam logic [3:0] START_PT  = 4'(SAMPLE_PT);
    localparam logic [3:0] CELL_PT   = 4'd15;
    localparam logic [3:0] CELL_LOAD = 4'd0;
`endif

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [3:0] bit_cnt, bit_cnt_nxt;
    logic [7:0] shift, shift_nxt;
    logic [7:0] data_nxt;
    logic       ready_nxt, err_nxt;
    logic       sync_1, line_s;
    logic [1:0] flush;
    logic       sample;

    // flush[1] stays set until line_s carries a real line value rather than the reset preset.
    // NOTE: every flop is written with <= so all of them update from pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            sync_1 <= 1'b1;
            line_s <= 1'b1;
            flush  <= 2'b11;
        end else begin
            sync_1 <= uart_recH;
            line_s <= sync_1;
            flush  <= {flush[0], 1'b0};
        end
    end

`ifdef U_RECV_MAJORITY_EN
    logic [1:0] hist;

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) hist <= 2'b11;
        else            hist <= {hist[0], line_s};
    end

    assign sample = (hist[1] & hist[0]) | (hist[1] & line_s) | (hist[0] & line_s);
`else
    assign sample = line_s;
`endif

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 4'd1;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        data_nxt    = rec_dataH;
        ready_nxt   = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt     = 4'd0;
                bit_cnt_nxt = 4'd0;
                if (flush[1])     state_nxt = BREAK;
                else if (!line_s) state_nxt = START;
            end
            START: begin
                if (cnt == START_PT) begin
                    cnt_nxt   = CELL_LOAD;
                    state_nxt = sample ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CELL_PT) begin
                    shift_nxt   = {sample, shift[7:1]};
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (cnt == CELL_PT) begin
                    if (sample) begin
                        data_nxt  = shift;
                        ready_nxt = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_nxt = 4'd0;
                if (line_s && !flush[1]) state_nxt = IDLE;
            end
            default: begin
                cnt_nxt   = 4'd0;
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: the shift register is reset as well, so a mid-word reset leaves no partial word behind.
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            bit_cnt    <= 4'd0;
            shift      <= 8'h00;
            rec_dataH  <= 8'h00;
            rec_readyH <= 1'b0;
            rec_errH   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shift      <= shift_nxt;
            rec_dataH  <= data_nxt;
            rec_readyH <= ready_nxt;
            rec_errH   <= err_nxt;
        end
    end

    assign rec_busyH = (state != IDLE);

endmodule

// File: tb/tb_u_recv.sv
// tb_u_recv -- per-tick scoreboard for u_recv: each stimulus task plans the expected
// busy/ready/err/data timeline from UART frame timing, and a negedge monitor compares every tick.
`timescale 1ns/1ps
module tb_u_recv;

`ifdef U_RECV_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    // Line fall to result pulse: 2 synchronizer clocks + 1 detect clock + result in cycle 152.
    localparam int LAT  = 155 + MAJ;
    localparam int MAXT = 16384;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_l = 1'b1;
    logic       uart_recH = 1'b1;
    logic [7:0] rec_dataH;
    logic       rec_readyH;
    logic       rec_errH;
    logic       rec_busyH;

    u_recv u_dut (
        .sys_clk   (sys_clk),
        .sys_rst_l (sys_rst_l),
        .uart_recH (uart_recH),
        .rec_dataH (rec_dataH),
        .rec_readyH(rec_readyH),
        .rec_errH  (rec_errH),
        .rec_busyH (rec_busyH)
    );

    always #5 sys_clk = ~sys_clk;

    int tick = 0;
    always @(posedge sys_clk) tick = tick + 1;

    bit         exp_ready [MAXT];
    bit         exp_err   [MAXT];
    bit         exp_busy  [MAXT];
    bit         exp_clr   [MAXT];
    logic [7:0] exp_word  [MAXT];
    logic [7:0] exp_data = 8'h00;
    bit         mon_on   = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @tick %0d: got %0h, expected %0h", tag, tick, got, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (mon_on && tick < MAXT) begin
            if (exp_clr[tick])   exp_data = 8'h00;
            if (exp_ready[tick]) exp_data = exp_word[tick];
            check("ready", 32'(rec_readyH), 32'(exp_ready[tick]));
            check("err",   32'(rec_errH),   32'(exp_err[tick]));
            check("busy",  32'(rec_busyH),  32'(exp_busy[tick]));
            check("data",  32'(rec_dataH),  32'(exp_data));
        end
    end

    task automatic plan_busy(input int a, input int b);
        for (int i = a; i <= b; i++) if (i < MAXT) exp_busy[i] = 1'b1;
    endtask

    task automatic plan_ready(input int t, input logic [7:0] w);
        if (t < MAXT) begin
            exp_ready[t] = 1'b1;
            exp_word[t]  = w;
        end
    endtask

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            uart_recH = v;
            @(negedge sys_clk);
        end
    endtask

    // One 16x frame; optional 1-clock inversion at offset 8 of each data cell, optional low stop.
    task automatic send_frame(input logic [7:0] w, input bit glitch, input int stop_low);
        drive(1'b0, 16);
        for (int b = 0; b < 8; b++) begin
            if (glitch) begin
                drive(w[b], 8);
                drive(~w[b], 1);
                drive(w[b], 7);
            end else begin
                drive(w[b], 16);
            end
        end
        if (stop_low == 0) begin
            drive(1'b1, 16);
        end else begin
            drive(1'b0, stop_low);
            drive(1'b1, 2);
        end
    endtask

    task automatic good_word(input logic [7:0] w);
        int n0 = tick;
        plan_busy(n0 + 3, n0 + LAT - 1);
        plan_ready(n0 + LAT, w);
        send_frame(w, 1'b0, 0);
    endtask

    task automatic glitch_word(input logic [7:0] w, input logic [7:0] expect_w);
        int n0 = tick;
        plan_busy(n0 + 3, n0 + LAT - 1);
        plan_ready(n0 + LAT, expect_w);
        send_frame(w, 1'b1, 0);
    endtask

    // Stop held low for s clocks: line returns high at n0+144+s, BREAK ends two clocks later.
    task automatic bad_word(input logic [7:0] w, input int s);
        int n0 = tick;
        plan_busy(n0 + 3, n0 + 146 + s);
        if (n0 + LAT < MAXT) exp_err[n0 + LAT] = 1'b1;
        send_frame(w, 1'b0, s);
    endtask

    task automatic false_start(input int len);
        int n0 = tick;
        plan_busy(n0 + 3, n0 + 10 + MAJ);
        drive(1'b0, len);
        drive(1'b1, 20);
    endtask

    task automatic reset_mid_word(input logic [7:0] w);
        int n0 = tick;
        int r;
        int q;
        int h;
        plan_busy(n0 + 3, n0 + 80);
        drive(1'b0, 16);
        for (int b = 0; b < 4; b++) drive(w[b], 16);
        r = tick;
        uart_recH = 1'b0;
        #2 sys_rst_l = 1'b0;
        #1;
        check("rst_data",  32'(rec_dataH),  32'h0);
        check("rst_ready", 32'(rec_readyH), 32'h0);
        check("rst_err",   32'(rec_errH),   32'h0);
        check("rst_busy",  32'(rec_busyH),  32'h0);
        for (int i = r + 1; i <= r + 5; i++) exp_clr[i] = 1'b1;
        q = r + 5;
        h = q + 40;
        plan_busy(q + 1, h + 2);
        repeat (5) @(negedge sys_clk);
        sys_rst_l = 1'b1;
        drive(1'b0, 40);
        drive(1'b1, 10);
    endtask

    initial begin
        #60000000;
        $display("FAIL watchdog: no summary after %0d ticks", tick);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int q;
        #1 sys_rst_l = 1'b0;
        mon_on = 1'b1;
        repeat (4) @(negedge sys_clk);
        q = tick;
        plan_busy(q + 1, q + 2);
        sys_rst_l = 1'b1;
        drive(1'b1, 20);

        good_word(8'hA5);
        drive(1'b1, 10);

        good_word(8'h00);
        good_word(8'hFF);
        good_word(8'h3C);
        drive(1'b1, 10);

        false_start(4);

        bad_word(8'h55, 40);
        drive(1'b1, 10);
        good_word(8'h81);
        drive(1'b1, 10);

        reset_mid_word(8'hC3);
        good_word(8'h7E);
        drive(1'b1, 10);

`ifdef U_RECV_MAJORITY_EN
        glitch_word(8'hF0, 8'hF0);
`else
        glitch_word(8'hF0, 8'h0F);
`endif
        drive(1'b1, 10);

        for (int k = 0; k < 20; k++) begin
            int kind = int'($urandom_range(0, 9));
            logic [7:0] w = 8'($urandom);
            if (kind == 0) begin
                false_start(int'($urandom_range(1, 6)));
            end else if (kind == 1) begin
                bad_word(w, int'($urandom_range(12, 40)));
            end else begin
                good_word(w);
            end
            if ($urandom_range(0, 2) != 0) drive(1'b1, int'($urandom_range(1, 20)));
        end

        drive(1'b1, 40);
        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
